// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared state encoding and bit-order constants for the serial transmitter
package serial_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic MSB_FIRST = 1'b1;
  localparam logic LSB_FIRST = 1'b0;

endpackage

// File: rtl/serial_tx_hold_buf.sv
// rtl/serial_tx_hold_buf.sv - one-entry valid/ready hold register for data and bit order
module serial_tx_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic             pop,
  output logic             hold_valid,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_msb_first
);

  // Accept and pop are mutually exclusive: accept needs an empty buffer, pop a full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid     <= 1'b0;
      hold_data      <= '0;
      hold_msb_first <= 1'b0;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end else if (in_valid && !hold_valid) begin
      hold_valid     <= 1'b1;
      hold_data      <= in_data;
      hold_msb_first <= in_msb_first;
    end
  end

  assign in_ready = !hold_valid;

endmodule

// File: rtl/serial_tx_shifter.sv
// rtl/serial_tx_shifter.sv - parallel-in serial-out transmitter with per-word bit order and frame markers
module serial_tx_shifter
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CNT_WIDTH = $clog2(WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] PENULT_IDX = CNT_WIDTH'(WIDTH - 2);

  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;
  logic             hold_msb_first;
  logic             pop;

  serial_tx_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_msb_first   (in_msb_first),
    .pop            (pop),
    .hold_valid     (hold_valid),
    .hold_data      (hold_data),
    .hold_msb_first (hold_msb_first)
  );

  state_t               state, state_next;
  logic [WIDTH-1:0]     shreg, shreg_next;
  logic [CNT_WIDTH-1:0] bit_cnt, bit_cnt_next;
  logic                 msb_reg, msb_next;
  logic                 so_next, sv_next, fs_next, fe_next;

  // Bit 0 of a fresh word goes straight to serial_out at the load edge; the shifter keeps the rest.
  logic             load_bit;
  logic [WIDTH-1:0] load_rem;
  assign load_bit = (hold_msb_first == MSB_FIRST) ? hold_data[WIDTH-1] : hold_data[0];
  assign load_rem = (hold_msb_first == LSB_FIRST) ? (hold_data >> 1) : (hold_data << 1);

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    msb_next     = msb_reg;
    so_next      = serial_out;
    sv_next      = 1'b0;
    fs_next      = 1'b0;
    fe_next      = 1'b0;
    pop          = 1'b0;
    if (enable) begin
      if ((state == ST_IDLE || bit_cnt == LAST_IDX) && hold_valid) begin
        pop          = 1'b1;
        state_next   = ST_SHIFT;
        shreg_next   = load_rem;
        bit_cnt_next = '0;
        msb_next     = hold_msb_first;
        so_next      = load_bit;
        sv_next      = 1'b1;
        fs_next      = 1'b1;
      end else if (state == ST_IDLE || bit_cnt == LAST_IDX) begin
        state_next = ST_IDLE;
        so_next    = 1'b0;
      end else begin
        so_next      = (msb_reg == MSB_FIRST) ? shreg[WIDTH-1] : shreg[0];
        shreg_next   = (msb_reg == MSB_FIRST) ? (shreg << 1) : (shreg >> 1);
        bit_cnt_next = bit_cnt + 1'b1;
        sv_next      = 1'b1;
        fe_next      = (bit_cnt == PENULT_IDX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      msb_reg      <= 1'b0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
    end else begin
      state        <= state_next;
      shreg        <= shreg_next;
      bit_cnt      <= bit_cnt_next;
      msb_reg      <= msb_next;
      serial_out   <= so_next;
      serial_valid <= sv_next;
      frame_start  <= fs_next;
      frame_end    <= fe_next;
    end
  end

  assign busy = (state == ST_SHIFT) || hold_valid;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// tb/tb_serial_tx_shifter.sv - scoreboard bench for serial_tx_shifter
module tb_serial_tx_shifter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_msb_first;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  serial_tx_shifter #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic s;
    logic e;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  int   max_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] data, input logic msb);
    for (int i = 0; i < WIDTH; i++) begin
      int idx;
      idx = msb ? (WIDTH - 1 - i) : i;
      q.push_back({data[idx], (i == 0), (i == WIDTH - 1)});
    end
  endtask

  // Drives one word and returns #1 after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] data, input logic msb);
    bit done;
    done = 0;
    in_valid     = 1'b1;
    in_data      = data;
    in_msb_first = msb;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        push_word(data, msb);
        done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) done = 1;
    end
    chk("drain", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && serial_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (q.size() == 0) begin
        chk("unexpected_bit", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("bit", serial_out, mon_e.b);
        chk("frame_start", frame_start, mon_e.s);
        chk("frame_end", frame_end, mon_e.e);
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    enable       = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_msb_first = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      chk("idle_valid", serial_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", in_ready, 1);
      chk("idle_out", serial_out, 0);
      @(posedge clk);
      #1;
    end

    // 2: 0xA5 MSB-first, latency and busy fall
    send(8'hA5, 1'b1);
    @(negedge clk);
    chk("lat_e0", serial_valid, 0);
    chk("busy_held", busy, 1);
    @(negedge clk);
    chk("lat_e1", serial_valid, 1);
    wait_drain();
    chk("busy_fall", busy, 0);

    // 3: 0x96 LSB-first
    send(8'h96, 1'b0);
    wait_drain();
    chk("busy_fall2", busy, 0);

    // 4: back-to-back, mixed order
    max_run = 0;
    send(8'h96, 1'b1);
    send(8'h5A, 1'b0);
    @(negedge clk);
    chk("ready_held", in_ready, 0);
    wait_drain();
    chk("contig_run", max_run, 16);

    // 5: stall after 3rd bit
    send(8'hA5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", serial_valid, 0);
      chk("stall_out", serial_out, 1);
      chk("stall_fe", frame_end, 0);
    end
    enable = 1'b1;
    wait_drain();

    // 6: reset during 5th bit with a held word
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", serial_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    rst = 1'b0;
    chk("rst_valid", serial_valid, 0);
    chk("rst_out", serial_out, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_fe", frame_end, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_valid", serial_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    send(8'h3C, 1'b1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx_shifter.md
Name: serial_tx_shifter

Overview:
Parallel-in, serial-out transmitter and the counterpart of the team's universal shift register receive path. It accepts WIDTH-bit words over a valid/ready handshake into a one-entry hold buffer. It then shifts each word out one bit per enabled cycle, MSB-first or LSB-first per word, with frame markers. It feeds serial links and bit-bang style peripherals. A one-word buffer gives gapless back-to-back frames.

Parameters:
WIDTH, 8, data word width in bits; must be >= 2.
CNT_WIDTH, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
enable  input  1  shift-engine clock enable; low stalls bit emission
in_valid  input  1  in_data and in_msb_first are valid
in_ready  output  1  hold buffer empty; a word is accepted when in_valid && in_ready at an edge
in_data  input  WIDTH  word to transmit
in_msb_first  input  1  bit order for this word: 1 = MSB first, 0 = LSB first
serial_out  output  1  current serial bit
serial_valid  output  1  serial_out carries a frame bit this cycle
frame_start  output  1  high with the first bit of a word
frame_end  output  1  high with the last bit of a word
busy  output  1  shift engine active or hold buffer full

Behaviour:
- Interface: one clock domain, clock port clk; reset port rst is synchronous and active-high. No asynchronous reset.
- Reset values: serial_out=0, serial_valid=0, frame_start=0, frame_end=0, busy=0, in_ready=1, engine in state IDLE, hold buffer empty.
- Reset mid-operation: the word in flight and any held word are discarded. Outputs return to reset values after the reset edge.
- in_ready = !hold_valid, driven from a register with no combinational path from in_valid. in_ready stays low during the edge at which the hold buffer drains. It rises in the following cycle.
- The handshake is independent of enable. Words are accepted while the engine is stalled.
- The hold buffer latches in_data and in_msb_first together.
- Engine states:
  - IDLE: at an edge where enable=1 and hold_valid=1, load the shifter from the hold buffer, clear hold_valid, set bit_cnt=0, and go to SHIFT.
  - SHIFT: at each edge where enable=1, present the next bit and increment bit_cnt.
  - After the bit with bit_cnt=WIDTH-1: if hold_valid=1, load the next word at the same edge and stay in SHIFT, with no idle cycle between frames. Otherwise go to IDLE.
- Latency: a word accepted at edge E0 appears as its first bit after edge E0+1, provided enable=1 and the engine is idle.
- Each bit is presented for exactly one cycle with serial_valid=1. frame_start is high only with bit 0. frame_end is high only with bit WIDTH-1.
- Stall: at an edge where enable=0, serial_valid, frame_start and frame_end are cleared to 0. serial_out, the shifter and bit_cnt hold. The next enabled edge presents the next untransmitted bit; no bit is repeated or lost.
- Bit order: msb_first=1 emits in_data[WIDTH-1] down to in_data[0]. msb_first=0 emits in_data[0] up to in_data[WIDTH-1].
- In IDLE: serial_out=0 and serial_valid=0.
- busy = (state==SHIFT) || hold_valid.
- Sustained throughput is one word per WIDTH enabled cycles. With in_valid held high, the hold buffer always refills before the current frame ends, because WIDTH >= 2.

Decomposition:
- Shared package serial_tx_pkg holds:
  - the state encoding localparams ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - the bit-order constants MSB_FIRST=1'b1 and LSB_FIRST=1'b0.
- One sub-module, serial_tx_hold_buf: a one-entry valid/ready register holding data and msb_first, with a pop input from the engine.
- The shift engine stays in the top level.

Test Plan:
1. Reset, then idle 10 cycles -> serial_valid=0, busy=0, in_ready=1, serial_out=0 throughout.
2. Send 0xA5 with msb_first=1 at edge E0, enable=1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting after E0+1. frame_start is high on the 1st bit and frame_end on the 8th. busy falls after the last bit.
3. Send 0x96 with msb_first=0 -> bits 0,1,1,0,1,0,0,1, each with serial_valid=1.
4. Send 0x96 (MSB-first) then 0x5A (LSB-first) back-to-back with in_valid held high:
   - 16 contiguous valid bits 1,0,0,1,0,1,1,0 then 0,1,0,1,1,0,1,0;
   - frame_end on bit 8 and frame_start on bit 9 in adjacent cycles;
   - in_ready low while the second word is held.
5. Send 0xA5 MSB-first and drop enable for 3 cycles after the 3rd bit -> serial_valid=0 for 3 cycles. The remaining bits 0,0,1,0,1 follow unchanged, for 8 valid bits in total, with frame_end on the last.
6. Assert rst during the 5th bit with a second word held -> after the reset edge all outputs are at reset values and in_ready=1. No further valid bits appear until a new word is sent.
